// File: rtl/reset_seq_pkg.sv
// Shared state type, default parameters and counter sizing for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_RDY = 2'd1,
        GAP      = 2'd2,
        DONE     = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_STAGE_GAP      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // The one counter serves hold, gap and timeout, so it must reach the largest of the three.
    function automatic int cnt_width(input int hold_c, input int gap_c, input int tmo_c);
        int m;
        m = hold_c;
        if (gap_c > m) m = gap_c;
        if (tmo_c > m) m = tmo_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module reset_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: holds all domains, then releases them in index order as each reports ready.
// Optional feature RESET_SEQ_TIMEOUT_EN: bounded wait for dom_ready with a sticky timeout_err flag.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_ready,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   seq_done,
    output logic                   timeout_err,
    output logic [((NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1)-1:0] cur_domain
);

    localparam int DW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES);
    localparam logic [DW-1:0] LAST_DOM = DW'(NUM_DOMAINS - 1);

    seq_state_e             state_q, state_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   done_q, done_d;
    logic [DW-1:0]          cur_q, cur_d;
    logic                   cnt_clr, cnt_tc;
    logic [CW-1:0]          cnt_term;
    logic                   rdy_seen, advance;
`ifdef RESET_SEQ_TIMEOUT_EN
    logic                   tmo_q, tmo_d, tmo_hit;
`endif

    reset_seq_counter #(.W(CW)) u_counter (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (cnt_clr),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    // Mask-based select keeps the index width independent of NUM_DOMAINS.
    assign rdy_seen = |(dom_ready & (NUM_DOMAINS'(1) << cur_q));

    always_comb begin
        state_d  = state_q;
        dom_d    = dom_q;
        done_d   = done_q;
        cur_d    = cur_q;
        cnt_clr  = 1'b0;
        cnt_term = CW'(HOLD_CYCLES - 1);
        advance  = rdy_seen;
`ifdef RESET_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
        tmo_hit  = 1'b0;
`endif
        if (sw_rst_req) begin
            state_d = HOLD;
            dom_d   = '0;
            done_d  = 1'b0;
            cur_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_tc) begin
                        state_d = WAIT_RDY;
                        dom_d   = NUM_DOMAINS'(1);
                        cur_d   = '0;
                        cnt_clr = 1'b1;
                    end
                end
                WAIT_RDY: begin
`ifdef RESET_SEQ_TIMEOUT_EN
                    cnt_term = CW'(TIMEOUT_CYCLES - 1);
                    tmo_hit  = !rdy_seen && cnt_tc;
                    advance  = rdy_seen || tmo_hit;
                    tmo_d    = tmo_q || tmo_hit;
`endif
                    if (advance) begin
                        cnt_clr = 1'b1;
                        if (cur_q == LAST_DOM) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            // No gap: next domain goes out on the same edge the ready is taken.
                            cur_d = cur_q + DW'(1);
                            dom_d = dom_q | (NUM_DOMAINS'(1) << cur_d);
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    cnt_term = CW'(STAGE_GAP);
                    if (cnt_tc) begin
                        state_d = WAIT_RDY;
                        cur_d   = cur_q + DW'(1);
                        dom_d   = dom_q | (NUM_DOMAINS'(1) << cur_d);
                        cnt_clr = 1'b1;
                    end
                end
                DONE: begin
                    dom_d  = '1;
                    done_d = 1'b1;
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOLD;
            dom_q   <= '0;
            done_q  <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            cur_q   <= cur_d;
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    // Sticky across software re-sequence; only the chip reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign dom_rst_n  = dom_q;
    assign seq_done   = done_q;
    assign cur_domain = cur_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes, monitors pop and compare.
module tb_reset_sequencer;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        bit         chk;
        logic [3:0] dom;
        logic       done;
        logic       tmo;
        logic [1:0] cur;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, sw_rst_req;
    logic [3:0] dom_ready, dom_rst_n;
    logic       seq_done, timeout_err;
    logic [1:0] cur_domain;

    logic       reset_n1, sw1, ready1, dom1, done1, tmo1, cur1;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(16), .STAGE_GAP(8), .TIMEOUT_CYCLES(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .sw_rst_req(sw_rst_req), .dom_ready(dom_ready),
        .dom_rst_n(dom_rst_n), .seq_done(seq_done), .timeout_err(timeout_err), .cur_domain(cur_domain)
    );

    reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(3), .STAGE_GAP(0), .TIMEOUT_CYCLES(32)) u_dut1 (
        .clk(clk), .reset_n(reset_n1), .sw_rst_req(sw1), .dom_ready(ready1),
        .dom_rst_n(dom1), .seq_done(done1), .timeout_err(tmo1), .cur_domain(cur1)
    );

    task automatic push0(input int c, input bit chk, input logic [3:0] d, input logic dn,
                         input logic tm, input logic [1:0] cu);
        exp_t e;
        e.cyc = c; e.chk = chk; e.dom = d; e.done = dn; e.tmo = tm; e.cur = cu;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input bit chk, input logic d, input logic dn);
        exp_t e;
        e.cyc = c; e.chk = chk; e.dom = {3'b000, d}; e.done = dn; e.tmo = 1'b0; e.cur = 2'd0;
        q1.push_back(e);
    endtask

    // Each ready is sampled on the edge after its domain's release, so stages are 1+8+1 edges apart.
    task automatic push_seq(input int b, input logic tm);
        push0(b + 16, 1, 4'b0001, 1'b0, tm, 2'd0);
        push0(b + 26, 1, 4'b0011, 1'b0, tm, 2'd1);
        push0(b + 36, 1, 4'b0111, 1'b0, tm, 2'd2);
        push0(b + 46, 1, 4'b1111, 1'b0, tm, 2'd3);
        push0(b + 47, 1, 4'b1111, 1'b1, tm, 2'd3);
    endtask

    task automatic wait_edge(input int e);
        while (edge_no < e) @(negedge clk);
    endtask

    task automatic sw_pulse(input int s, input logic [3:0] rdy);
        wait_edge(s - 1);
        sw_rst_req = 1'b1;
        dom_ready  = rdy;
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    // Monitor for the 4-domain instance: every visible output change is one scoreboard entry.
    initial begin
        logic [8:0] got, last;
        bit seen;
        exp_t e;
        seen = 1'b0;
        last = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            got = {dom_rst_n, seq_done, timeout_err, cur_domain};
            if (!seen || got != last) begin
                seen = 1'b1;
                last = got;
                n_cmp++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL main_unexpected edge=%0d got dom=%b done=%b tmo=%b cur=%0d, required no change",
                             edge_no, dom_rst_n, seq_done, timeout_err, cur_domain);
                end else begin
                    e = q0.pop_front();
                    if ((e.chk && e.cyc != edge_no) || got != {e.dom, e.done, e.tmo, e.cur}) begin
                        n_fail++;
                        $display("FAIL main_seq got edge=%0d dom=%b done=%b tmo=%b cur=%0d, required edge=%0d dom=%b done=%b tmo=%b cur=%0d",
                                 edge_no, dom_rst_n, seq_done, timeout_err, cur_domain,
                                 e.cyc, e.dom, e.done, e.tmo, e.cur);
                    end
                end
            end
        end
    end

    // Monitor for the single-domain, zero-gap instance.
    initial begin
        logic [3:0] got, last;
        bit seen;
        exp_t e;
        seen = 1'b0;
        last = '0;
        forever begin
            @(posedge clk or negedge reset_n1);
            #1;
            got = {dom1, done1, tmo1, cur1};
            if (!seen || got != last) begin
                seen = 1'b1;
                last = got;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_unexpected edge=%0d got dom=%b done=%b tmo=%b cur=%0d, required no change",
                             edge_no, dom1, done1, tmo1, cur1);
                end else begin
                    e = q1.pop_front();
                    if ((e.chk && e.cyc != edge_no) || got != {e.dom[0], e.done, e.tmo, e.cur[0]}) begin
                        n_fail++;
                        $display("FAIL single_seq got edge=%0d dom=%b done=%b tmo=%b cur=%0d, required edge=%0d dom=%b done=%b tmo=0 cur=0",
                                 edge_no, dom1, done1, tmo1, cur1, e.cyc, e.dom[0], e.done);
                    end
                end
            end
        end
    end

    initial begin
        int b, t0, s, s2, s3, t1, s4, s5, end_e;
        exp_t e;
        reset_n = 1'b1; reset_n1 = 1'b1; sw_rst_req = 1'b0; sw1 = 1'b0;
        dom_ready = 4'hF; ready1 = 1'b0;

        // Reset state of both instances.
        push0(0, 0, 4'b0000, 1'b0, 1'b0, 2'd0);
        push1(0, 0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0; reset_n1 = 1'b0;
        repeat (3) @(negedge clk);

        // Single domain, no gap: release at HOLD edge, done on the first edge ready is sampled.
        reset_n1 = 1'b1;
        b = edge_no;
        push1(b + 3, 1, 1'b1, 1'b0);
        push1(b + 10, 1, 1'b1, 1'b1);
        push1(b + 15, 1, 1'b0, 1'b0);
        push1(b + 18, 1, 1'b1, 1'b0);
        push1(b + 19, 1, 1'b1, 1'b1);
        wait_edge(b + 9);
        ready1 = 1'b1;
        wait_edge(b + 14);
        sw1 = 1'b1;
        @(negedge clk);
        sw1 = 1'b0;
        wait_edge(b + 22);

        // Power-up sequence, all ready high.
        reset_n = 1'b1;
        t0 = edge_no;
        push_seq(t0, 1'b0);
        wait_edge(t0 + 48);
        dom_ready = 4'b1110;   // a drop after acceptance must be ignored

        // Software re-sequence from DONE repeats the same timing.
        s = t0 + 50;
        push0(s, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        push_seq(s, 1'b0);
        sw_pulse(s, 4'hF);

        // dom_ready[1] late by 100 cycles (or timing out after 32 when the timeout is built).
        s2 = s + 50;
        push0(s2, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        push0(s2 + 16, 1, 4'b0001, 1'b0, 1'b0, 2'd0);
        push0(s2 + 26, 1, 4'b0011, 1'b0, 1'b0, 2'd1);
        if (TMO_EN) begin
            push0(s2 + 58, 1, 4'b0011, 1'b0, 1'b1, 2'd1);
            push0(s2 + 67, 1, 4'b0111, 1'b0, 1'b1, 2'd2);
            push0(s2 + 77, 1, 4'b1111, 1'b0, 1'b1, 2'd3);
            push0(s2 + 78, 1, 4'b1111, 1'b1, 1'b1, 2'd3);
        end else begin
            push0(s2 + 135, 1, 4'b0111, 1'b0, 1'b0, 2'd2);
            push0(s2 + 145, 1, 4'b1111, 1'b0, 1'b0, 2'd3);
            push0(s2 + 146, 1, 4'b1111, 1'b1, 1'b0, 2'd3);
        end
        sw_pulse(s2, 4'b1101);
        wait_edge(s2 + 125);
        dom_ready = 4'hF;

        // Chip reset mid-GAP drops every domain without a clock edge, then restarts from HOLD.
        s3 = s2 + 150;
        push0(s3, 1, 4'b0000, 1'b0, TMO_EN, 2'd0);
        push0(s3 + 16, 1, 4'b0001, 1'b0, TMO_EN, 2'd0);
        sw_pulse(s3, 4'hF);
        wait_edge(s3 + 20);
        push0(s3 + 20, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        t1 = edge_no;
        push_seq(t1, 1'b0);

        // sw_rst_req and dom_ready[0] on the same edge: the request wins.
        s4 = t1 + 50;
        push0(s4, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        push0(s4 + 16, 1, 4'b0001, 1'b0, 1'b0, 2'd0);
        sw_pulse(s4, 4'h0);
        s5 = s4 + 30;
        push0(s5, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        push_seq(s5, 1'b0);
        sw_pulse(s5, 4'hF);
        end_e = s5 + 52;

`ifdef RESET_SEQ_TIMEOUT_EN
        // dom_ready[2] stuck low: timeout 32 edges after release, domain 3 nine edges later, flag survives sw.
        begin
            int s6, s7;
            s6 = s5 + 50;
            push0(s6, 1, 4'b0000, 1'b0, 1'b0, 2'd0);
            push0(s6 + 16, 1, 4'b0001, 1'b0, 1'b0, 2'd0);
            push0(s6 + 26, 1, 4'b0011, 1'b0, 1'b0, 2'd1);
            push0(s6 + 36, 1, 4'b0111, 1'b0, 1'b0, 2'd2);
            push0(s6 + 68, 1, 4'b0111, 1'b0, 1'b1, 2'd2);
            push0(s6 + 77, 1, 4'b1111, 1'b0, 1'b1, 2'd3);
            push0(s6 + 78, 1, 4'b1111, 1'b1, 1'b1, 2'd3);
            sw_pulse(s6, 4'b1011);
            s7 = s6 + 90;
            push0(s7, 1, 4'b0000, 1'b0, 1'b1, 2'd0);
            push_seq(s7, 1'b1);
            sw_pulse(s7, 4'hF);
            end_e = s7 + 52;
        end
`endif

        wait_edge(end_e);
        while (q0.size() > 0) begin
            e = q0.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL main_missing got no change, required edge=%0d dom=%b done=%b tmo=%b cur=%0d",
                     e.cyc, e.dom, e.done, e.tmo, e.cur);
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL single_missing got no change, required edge=%0d dom=%b done=%b",
                     e.cyc, e.dom[0], e.done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no end of run by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
